// File: rtl/sw_debounce.sv
// Switch input conditioning: 2-flop synchroniser, shared ms-rate sample tick,
// per-bit debounce counters, clean levels plus 1-cycle rise/fall/change pulses.

// One debounced switch bit. A change is accepted only after STABLE_TICKS
// consecutive sample ticks disagree with the current debounced level.
module sw_debounce_bit #(
   parameter int STABLE_TICKS = 10,
   parameter int CW           = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic s,
   output logic db,
   output logic rise,
   output logic fall,
   output logic acc
);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt;

   // Accept strobe: this tick completes the run of mismatching samples.
   always_comb begin
      acc = tick && (s != db) && (cnt == LAST);
   end

   // Count mismatching ticks; any matching tick restarts the run.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt  <= '0;
         db   <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (tick) begin
            if (s == db) begin
               cnt <= '0;
            end else if (cnt == LAST) begin
               cnt  <= '0;
               db   <= s;
               rise <= s;
               fall <= ~s;
            end else begin
               cnt <= cnt + ONE;
            end
         end
      end
   end
endmodule

// Top: synchroniser, prescaler and an array of per-bit debouncers.
module sw_debounce #(
   parameter int WIDTH        = 16,
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_db,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_chg,
   output logic             tick
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(STABLE_TICKS + 1);
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PONE  = PW'(1);

   logic [WIDTH-1:0] s1, s2;
   logic [WIDTH-1:0] acc;
   logic [PW-1:0]    pcnt;

   // Two-flop synchroniser; only s2 feeds the debouncers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_in;
         s2 <= s1;
      end
   end

   // Prescaler: tick is registered, high the cycle after pcnt wraps.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pcnt <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (pcnt == PLAST);
         if (pcnt == PLAST) pcnt <= '0;
         else               pcnt <= pcnt + PONE;
      end
   end

   // Change pulse, registered alongside the per-bit rise/fall pulses.
   always_ff @(posedge clk) begin
      if (!rst) sw_chg <= 1'b0;
      else      sw_chg <= |acc;
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      sw_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS),
         .CW           (CW)
      ) u_bit (
         .clk  (clk),
         .rst  (rst),
         .tick (tick),
         .s    (s2[gi]),
         .db   (sw_db[gi]),
         .rise (sw_rise[gi]),
         .fall (sw_fall[gi]),
         .acc  (acc[gi])
      );
   end
endmodule
